// File: rtl/trng_axil_fifo_slave.sv
// AXI4-Lite slave that packs TRNG bits into 32-bit words and buffers them in a FIFO.
// Define TRNG_AXIL_HEALTH_EN to build the repetition-count health test.
module trng_axil_fifo_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            rnd_bit,
   input  logic                            rnd_valid,
   output logic                            trng_en,
   output logic                            irq
);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic          en, irq_en, unf, ovf, hfail;
   logic [31:0]   scratch, shreg, shreg_nxt, rd_word, status_word, rdata;
   logic [4:0]    bit_cnt;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   level;
   logic          bvalid, rvalid, irq_q;
   logic          wr_fire, rd_fire, empty, full, flush;
   logic          bit_take, word_done, push, push_ok, pop, health_trip;
   logic          unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   // Ready is offered only while no response of the same kind is pending.
   assign wr_fire     = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~S_AXI_ARESET;
   assign rd_fire     = S_AXI_ARVALID & ~rvalid & ~S_AXI_ARESET;
   assign empty       = (level == '0);
   assign full        = (level == (PW+1)'(FIFO_DEPTH));
   assign flush       = wr_fire & (S_AXI_AWADDR[3:2] == 2'd0) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
   assign bit_take    = rnd_valid & en & ~flush;
   assign shreg_nxt   = {rnd_bit, shreg[31:1]};
   assign word_done   = bit_take & (bit_cnt == 5'd31);
   assign push        = word_done & ~health_trip;
   assign pop         = rd_fire & (S_AXI_ARADDR[3:2] == 2'd2) & ~empty;
   assign push_ok     = push & (~full | pop);
   assign status_word = {16'd0, 8'(level), 3'd0, hfail, ovf, unf, full, empty};

`ifdef TRNG_AXIL_HEALTH_EN
   logic [5:0] run_cnt, run_nxt;
   logic       last_bit;

   // Run length saturates at 32, so a stuck source keeps discarding words.
   always_comb begin
      run_nxt = 6'd1;
      if (run_cnt != 6'd0 && rnd_bit == last_bit)
         run_nxt = (run_cnt == 6'd32) ? 6'd32 : run_cnt + 6'd1;
   end
   assign health_trip = bit_take & (run_nxt == 6'd32);

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || flush || !en) begin
         run_cnt  <= '0;
         last_bit <= 1'b0;
      end else if (bit_take) begin
         run_cnt  <= run_nxt;
         last_bit <= rnd_bit;
      end
   end
`else
   assign health_trip = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      case (S_AXI_ARADDR[3:2])
         2'd0:    rd_word = {29'd0, irq_en, 1'b0, en};
         2'd1:    rd_word = status_word;
         2'd2:    rd_word = empty ? 32'd0 : mem[rptr];
         default: rd_word = scratch;
      endcase
   end

   // Packer: partial word is dropped on flush or while disabled.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || flush || !en) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (bit_take) begin
         shreg   <= shreg_nxt;
         bit_cnt <= health_trip ? 5'd0 : bit_cnt + 5'd1;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (push_ok)
         mem[wptr] <= shreg_nxt;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push_ok)
            wptr <= wptr + PW'(1);
         if (pop)
            rptr <= rptr + PW'(1);
         level <= level + (PW+1)'(push_ok) - (PW+1)'(pop);
      end
   end

   // Hardware set of a sticky flag wins over a same-cycle software clear.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         en      <= 1'b0;
         irq_en  <= 1'b0;
         unf     <= 1'b0;
         ovf     <= 1'b0;
         hfail   <= 1'b0;
         scratch <= '0;
         bvalid  <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (wr_fire) begin
            case (S_AXI_AWADDR[3:2])
               2'd0: if (S_AXI_WSTRB[0]) begin
                  en     <= S_AXI_WDATA[0];
                  irq_en <= S_AXI_WDATA[2];
               end
               2'd1: if (S_AXI_WSTRB[0]) begin
                  if (S_AXI_WDATA[2]) unf   <= 1'b0;
                  if (S_AXI_WDATA[3]) ovf   <= 1'b0;
                  if (S_AXI_WDATA[4]) hfail <= 1'b0;
               end
               2'd3: for (int i = 0; i < 4; i++)
                  if (S_AXI_WSTRB[i]) scratch[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
               default: ;
            endcase
         end
         if (rd_fire && S_AXI_ARADDR[3:2] == 2'd2 && empty)
            unf <= 1'b1;
         if (push && full && !pop)
            ovf <= 1'b1;
         if (health_trip)
            hfail <= 1'b1;

         if (wr_fire)
            bvalid <= 1'b1;
         else if (S_AXI_BREADY)
            bvalid <= 1'b0;

         if (rd_fire) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
         end else if (S_AXI_RREADY) begin
            rvalid <= 1'b0;
         end

         irq_q <= irq_en & (~empty | ovf | hfail);
      end
   end

   assign S_AXI_AWREADY = wr_fire;
   assign S_AXI_WREADY  = wr_fire;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_ARREADY = rd_fire;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid;
   assign trng_en       = en;
   assign irq           = irq_q;
endmodule

// File: tb/tb_trng_axil_fifo_slave.sv
// Randomized bench for trng_axil_fifo_slave against a queue-based register/FIFO model.
// Define TRNG_AXIL_HEALTH_EN for both files to include the health-test scenario.
`timescale 1ns/1ps
module tb_trng_axil_fifo_slave;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        rnd_bit, rnd_valid, trng_en, irq;

   always #5 clk = ~clk;

   trng_axil_fifo_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .rnd_bit(rnd_bit), .rnd_valid(rnd_valid), .trng_en(trng_en), .irq(irq)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model
   logic        m_en, m_irq_en, m_unf, m_ovf, m_hf;
   logic [31:0] m_scratch, m_part;
   int          m_nbits;
   logic [31:0] m_q[$];
`ifdef TRNG_AXIL_HEALTH_EN
   int          m_run;
   logic        m_last;
`endif

   task automatic model_reset();
      m_en = 0; m_irq_en = 0; m_unf = 0; m_ovf = 0; m_hf = 0;
      m_scratch = '0; m_part = '0; m_nbits = 0; m_q.delete();
`ifdef TRNG_AXIL_HEALTH_EN
      m_run = 0; m_last = 0;
`endif
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = '0;
      s[0] = (m_q.size() == 0);
      s[1] = (m_q.size() == DEPTH);
      s[2] = m_unf;
      s[3] = m_ovf;
      s[4] = m_hf;
      s[15:8] = 8'(m_q.size());
      return s;
   endfunction

   task automatic model_bit(input logic b);
      logic trip;
      trip = 0;
      if (!m_en) return;
      m_part[m_nbits] = b;
      m_nbits++;
`ifdef TRNG_AXIL_HEALTH_EN
      if (m_run > 0 && b == m_last) m_run = (m_run < 32) ? m_run + 1 : 32;
      else m_run = 1;
      m_last = b;
      if (m_run == 32) begin m_hf = 1; m_nbits = 0; trip = 1; end
`endif
      if (!trip && m_nbits == 32) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_part);
         else m_ovf = 1;
         m_nbits = 0;
      end
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      case (a[3:2])
         2'd0: if (s[0]) begin
            m_en = d[0];
            m_irq_en = d[2];
            if (d[1] || !d[0]) begin
               m_nbits = 0;
`ifdef TRNG_AXIL_HEALTH_EN
               m_run = 0;
`endif
            end
            if (d[1]) m_q.delete();
         end
         2'd1: if (s[0]) begin
            if (d[2]) m_unf = 0;
            if (d[3]) m_ovf = 0;
            if (d[4]) m_hf = 0;
         end
         2'd3: for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
         default: ;
      endcase
   endtask

   task automatic model_read(input logic [3:0] a, output logic [31:0] v);
      case (a[3:2])
         2'd0: v = {29'd0, m_irq_en, 1'b0, m_en};
         2'd1: v = m_status();
         2'd2: if (m_q.size() == 0) begin m_unf = 1; v = '0; end
               else v = m_q.pop_front();
         default: v = m_scratch;
      endcase
   endtask

   // Driver tasks: each starts and ends 1ns after a rising edge.
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      #1;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(posedge clk); #2; n++; end
      if (n >= 20) check("write_handshake_timeout", 0, 1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      model_write(a, d, s);
      n = 0;
      while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) check("bvalid_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] v, input int hold);
      int n;
      araddr = a; arvalid = 1; rready = (hold == 0);
      #1;
      n = 0;
      while (!arready && n < 20) begin @(posedge clk); #2; n++; end
      if (n >= 20) check("read_handshake_timeout", 0, 1);
      @(posedge clk); #1;
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) check("rvalid_timeout", 0, 1);
      v = rdata;
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk); #1; end
         check("rdata_stable", rdata, v);
         check("rvalid_held", rvalid, 1);
         rready = 1;
      end
      @(posedge clk); #1;
      rready = 1;
   endtask

   task automatic rd_check(input string tag, input logic [3:0] a);
      logic [31:0] exp, got;
      model_read(a, exp);
      axi_read(a, got, 0);
      check(tag, got, exp);
   endtask

   task automatic send_bit(input logic b, input bit gaps);
      rnd_bit = b; rnd_valid = 1;
      @(posedge clk); #1;
      rnd_valid = 0;
      model_bit(b);
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 32; i++) send_bit(w[i], 1);
   endtask

   task automatic check_irq(input string tag);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check(tag, 32'(irq), 32'(m_irq_en & (m_q.size() != 0 || m_ovf || m_hf)));
      check({tag, "_en"}, 32'(trng_en), 32'(m_en));
   endtask

   logic [31:0] got, exp, first_word, w;

   initial begin
      awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      rnd_bit = 0; rnd_valid = 0;
      model_reset();

      // Reset with requests pending: nothing may be accepted.
      rst = 1; awvalid = 1; wvalid = 1; arvalid = 1; rnd_valid = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", 32'(awready), 0);
      check("rst_wready", 32'(wready), 0);
      check("rst_arready", 32'(arready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_trng_en", 32'(trng_en), 0);
      check("rst_rdata", rdata, 0);
      awvalid = 0; wvalid = 0; arvalid = 0; rnd_valid = 0;
      rst = 0;
      @(posedge clk); #1;

      rd_check("ctrl_reset", 4'h0);
      rd_check("status_reset", 4'h4);
      rd_check("data_empty", 4'h8);
      rd_check("scratch_reset", 4'hC);
      axi_read(4'h4, got, 0);
      check("status_underflow", got, 32'h5);
      model_read(4'h4, exp);
      axi_write(4'h4, 32'h1C, 4'hF);
      rd_check("status_w1c", 4'h4);

      // Known pattern, LSB first.
      axi_write(4'h0, 32'h1, 4'hF);
      check("trng_en_set", 32'(trng_en), 1);
      send_word(32'hA5A5_A5A5);
      axi_read(4'h4, got, 0);
      check("level_one", got, 32'h100);
      model_read(4'h4, exp);
      rd_check("data_a5", 4'h8);
      rd_check("status_after_pop", 4'h4);

      // Fill to overflow.
      first_word = $urandom;
      send_word(first_word);
      for (int i = 0; i < DEPTH; i++) send_word($urandom);
      axi_read(4'h4, got, 0);
      check("fill_status", got, 32'h100A);
      model_read(4'h4, exp);
      model_read(4'h8, exp);
      axi_read(4'h8, got, 0);
      check("fill_first_word", got, first_word);
      check("fill_first_model", got, exp);

      // Simultaneous pop and push while full.
      send_word($urandom);
      axi_write(4'h4, 32'h1C, 4'hF);
      rd_check("full_again", 4'h4);
      w = $urandom;
      for (int i = 0; i < 31; i++) send_bit(w[i], 0);
      rnd_bit = w[31]; rnd_valid = 1; araddr = 4'h8; arvalid = 1; rready = 1;
      #1;
      check("pop_push_arready", 32'(arready), 1);
      @(posedge clk); #1;
      rnd_valid = 0; arvalid = 0;
      got = rdata;
      exp = m_q.pop_front();
      model_bit(w[31]);
      check("pop_push_data", got, exp);
      @(posedge clk); #1;
      axi_read(4'h4, got, 0);
      check("pop_push_status", got, 32'h1002);
      model_read(4'h4, exp);

      // Scratch with partial strobes, and writes to DATA ignored.
      axi_write(4'hC, 32'hDEAD_BEEF, 4'b0011);
      axi_read(4'hC, got, 0);
      check("scratch_strb", got, 32'h0000_BEEF);
      axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
      rd_check("data_write_ignored", 4'h4);

      // irq, flush, partial word discard.
      axi_write(4'h0, 32'h5, 4'hF);
      check_irq("irq_level");
      axi_write(4'h0, 32'h7, 4'hF);
      rd_check("ctrl_flush_reads0", 4'h0);
      rd_check("status_flushed", 4'h4);
      axi_write(4'h4, 32'h1C, 4'hF);
      check_irq("irq_clear");
      for (int i = 0; i < 10; i++) send_bit($urandom_range(0, 1), 1);
      axi_write(4'h0, 32'h3, 4'hF);
      send_word(32'h1234_5678);
      axi_read(4'h8, got, 0);
      check("flush_partial", got, 32'h1234_5678);
      model_read(4'h8, exp);
      for (int i = 0; i < 7; i++) send_bit($urandom_range(0, 1), 1);
      axi_write(4'h0, 32'h0, 4'hF);
      axi_write(4'h0, 32'h1, 4'hF);
      send_word(32'h0F0F_3C3C);
      rd_check("en_clear_partial", 4'h8);

      // Read data held with RREADY low.
      send_word($urandom);
      model_read(4'h8, exp);
      axi_read(4'h8, got, 3);
      check("held_read_data", got, exp);

      // Randomized mix.
      for (int it = 0; it < 250; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               int nb;
               nb = $urandom_range(1, 40);
               for (int i = 0; i < nb; i++) send_bit($urandom_range(0, 1), 1);
            end
            4, 5: rd_check("rand_data", 4'h8);
            6: rd_check("rand_status", 4'h4);
            7: axi_write(4'h0, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                                1'($urandom_range(0, 3) != 0)}, 4'($urandom_range(0, 15)));
            8: axi_write(4'h4, $urandom, 4'($urandom_range(0, 15)));
            default: begin
               axi_write(4'hC, $urandom, 4'($urandom_range(0, 15)));
               rd_check("rand_scratch", 4'hC);
            end
         endcase
         if (it % 25 == 0) check_irq("rand_irq");
      end
      rd_check("rand_final_status", 4'h4);
      rd_check("rand_final_ctrl", 4'h0);

`ifdef TRNG_AXIL_HEALTH_EN
      axi_write(4'h0, 32'h7, 4'hF);
      axi_write(4'h4, 32'h1C, 4'hF);
      for (int i = 0; i < 32; i++) send_bit(1'b1, 1);
      axi_read(4'h4, got, 0);
      check("health_status", got, 32'h11);
      model_read(4'h4, exp);
      check_irq("health_irq");
      axi_write(4'h4, 32'h10, 4'hF);
      rd_check("health_cleared", 4'h4);
`endif

      // Reset mid-transaction with responses pending and data queued.
      axi_write(4'h0, 32'h1, 4'hF);
      send_word($urandom);
      bready = 0; rready = 0;
      awaddr = 4'hC; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      araddr = 4'h4; arvalid = 1;
      #1;
      check("concurrent_awready", 32'(awready), 1);
      check("concurrent_arready", 32'(arready), 1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("pending_bvalid", 32'(bvalid), 1);
      check("pending_rvalid", 32'(rvalid), 1);
      rst = 1;
      @(posedge clk); #1;
      check("rst_drop_bvalid", 32'(bvalid), 0);
      check("rst_drop_rvalid", 32'(rvalid), 0);
      rst = 0; bready = 1; rready = 1;
      model_reset();
      @(posedge clk); #1;
      rd_check("post_rst_status", 4'h4);
      rd_check("post_rst_scratch", 4'hC);
      check_irq("post_rst_irq");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/trng_axil_fifo_slave.md
# trng_axil_fifo_slave

AXI4-Lite slave that collects the raw bit stream from the TRNG entropy core, packs it into 32-bit words, and buffers the words in a FIFO. Software reads the words through a memory-mapped DATA register and controls the core through CTRL and STATUS registers. The block sits between the TRNG core and the processor interconnect. It is the responder end of the AXI4-Lite master transactions issued by the bus or the VIP master.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses bits [3:2].
- FIFO_DEPTH, 16, number of 32-bit words; must be a power of 2, range 2..128.
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address. S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write address handshake.
- S_AXI_WDATA  in  32  write data. S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY). S_AXI_BVALID out 1 / S_AXI_BREADY in 1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address. S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read address handshake.
- S_AXI_RDATA  out  32  read data. S_AXI_RRESP  out  2  always 2'b00. S_AXI_RVALID out 1 / S_AXI_RREADY in 1  read data handshake.
- rnd_bit  in  1  raw entropy bit. rnd_valid  in  1  qualifies rnd_bit for one cycle.
- trng_en  out  1  enable to the TRNG core; mirrors CTRL.EN.
- irq  out  1  registered level interrupt.

## Operation
- Register map:
  - 0x0 CTRL (R/W): [0] EN, [1] FLUSH (write-1 pulse, always reads 0), [2] IRQ_EN.
  - 0x4 STATUS: [0] EMPTY, [1] FULL, [2] UNDERFLOW (write-1-to-clear), [3] OVERFLOW (W1C), [4] HEALTH_FAIL (W1C), [15:8] LEVEL. All other STATUS bits are read-only.
  - 0x8 DATA (RO): a read pops one word from the FIFO.
  - 0xC SCRATCH (R/W): honours WSTRB.
- CTRL writes honour WSTRB[0]. Writes to DATA are ignored, still receive OKAY, and have no side effect.
- Bit packing: on each cycle where rnd_valid=1 and EN=1, the packer shifts rnd_bit into bit 31 of the shift register and shifts the register right. After 32 bits the word is pushed into the FIFO and the bit counter resets.
- Push while the FIFO is full: the word is dropped and OVERFLOW is set.
- Clearing EN, or writing FLUSH, discards the partial word and resets the bit counter. FLUSH also empties the FIFO.
- DATA read while the FIFO is empty: returns 0x00000000 and sets UNDERFLOW.
- A push and a pop in the same cycle both succeed and LEVEL is unchanged, including when the FIFO is full.
- irq is asserted when IRQ_EN is set and (LEVEL != 0 or OVERFLOW or HEALTH_FAIL), registered by one cycle.

## Timing
- Reset values: every READY, BVALID, RVALID, irq and trng_en = 0; RDATA = 0; all registers = 0; FIFO empty.
- Write: AWREADY and WREADY pulse high together for one cycle, only when AWVALID, WVALID and !BVALID. The register update happens in that same cycle. BVALID rises the next cycle and holds until BREADY.
- Read: ARREADY pulses for one cycle when ARVALID and !RVALID. RDATA is registered and RVALID rises the next cycle, holding until RREADY. RDATA stays stable while RVALID=1.
- The FIFO pop occurs in the ARREADY cycle. LEVEL read back afterwards already reflects the pop.
- At most one write and one read outstanding; a read and a write may complete in the same cycle.
- Latency from the 32nd valid bit to the word being visible in LEVEL: one cycle.
- Reset asserted mid-transaction: any pending BVALID/RVALID is dropped and the partial word and FIFO contents are lost.

## Configuration
- TRNG_AXIL_HEALTH_EN defined:
  - The packer runs a repetition-count test.
  - 32 consecutive identical rnd_bit values (across word boundaries) set HEALTH_FAIL.
  - The word in progress at that point is discarded instead of pushed.
  - The run counter resets on FLUSH or when EN is cleared.
- TRNG_AXIL_HEALTH_EN undefined: no test logic is built; HEALTH_FAIL reads 0.

## Test plan
- Reset, then read 0x0/0x4/0x8/0xC -> 0x0, 0x1 (EMPTY), 0x0 with UNDERFLOW then set (STATUS=0x5), 0x0.
- Write CTRL=0x1, drive 32 rnd_valid bits of the pattern 0xA5A5A5A5 LSB-first -> STATUS LEVEL=1; DATA read = 0xA5A5A5A5; LEVEL=0.
- Fill FIFO_DEPTH+1 words -> FULL=1, OVERFLOW=1, LEVEL=16. The first word read back equals the first word pushed.
- Pop on DATA in the same cycle a word completes while FULL -> LEVEL stays 16, no OVERFLOW.
- Write SCRATCH=0xDEADBEEF with WSTRB=4'b0011 -> reads back 0x0000BEEF. Write STATUS=0x1C -> sticky bits clear.
- With TRNG_AXIL_HEALTH_EN: 32 bits of 1 -> HEALTH_FAIL=1, LEVEL=0, irq=1 when IRQ_EN=1.
